// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: drives an external 1-bit full adder one bit per
// clock, LSB first, and collects the sum and final carry.
module serial_add_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cr,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry;
   logic [CNT_W-1:0] idx;
   logic             last_bit;

   assign last_bit = (idx == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The adder inputs are only meaningful in RUN; hold them quiet otherwise.
   always_comb begin
      busy   = 1'b0;
      done   = 1'b0;
      fa_a   = 1'b0;
      fa_b   = 1'b0;
      fa_cin = 1'b0;
      case (state)
         RUN: begin
            busy   = 1'b1;
            fa_a   = a_reg[idx];
            fa_b   = b_reg[idx];
            fa_cin = carry;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // The index saturates on the last bit so it never leaves the operand range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         sum_out  <= '0;
         cout_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg    <= a_in;
                  b_reg    <= b_in;
                  carry    <= cin_in;
                  idx      <= '0;
                  sum_out  <= '0;
                  cout_out <= 1'b0;
               end
            end
            RUN: begin
               sum_out[idx] <= fa_sum;
               carry        <= fa_cr;
               if (last_bit) begin
                  cout_out <= fa_cr;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial addition controller that sequences a single shared 1-bit full adder (`full_adder_ds`, ports A/B/Cin → sum/cr) to add two WIDTH-bit operands, one bit per clock, LSB first.
- Owns the operand/result registers, the carry register and the bit counter.
- The full adder sits outside the block. This controller drives its inputs and captures its outputs.
- Handshake to the host: start / busy / done.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH), bit-index counter width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request to begin an addition; sampled only in IDLE
- a_in  input  WIDTH  operand A; latched when start is accepted
- b_in  input  WIDTH  operand B; latched when start is accepted
- cin_in  input  1  carry-in; latched when start is accepted
- fa_a  output  1  to full adder A
- fa_b  output  1  to full adder B
- fa_cin  output  1  to full adder Cin
- fa_sum  input  1  from full adder sum
- fa_cr  input  1  from full adder cr
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result valid
- sum_out  output  WIDTH  result sum, held until the next accepted start
- cout_out  output  1  final carry-out, held with sum_out

Behaviour:
- Reset (async assert, rst_n=0):
  - state=IDLE.
  - busy, done, fa_a, fa_b, fa_cin = 0.
  - sum_out = 0, cout_out = 0.
  - Operand regs, carry reg and bit index = 0.
  - Reset asserted mid-operation aborts the addition immediately; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On a clk edge with start=1: latch a_in, b_in into a_reg, b_reg; carry ← cin_in; idx ← 0; clear sum_out; state ← RUN.
  - start=0: remain in IDLE.
- RUN:
  - busy=1.
  - fa_a, fa_b and fa_cin are combinational: a_reg[idx], b_reg[idx], carry.
  - Each edge: sum_out[idx] ← fa_sum; carry ← fa_cr; idx ← idx+1.
  - When idx==WIDTH-1 at the edge: cout_out ← fa_cr; state ← DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0; state ← IDLE on the next edge.
- Outside RUN, fa_a, fa_b and fa_cin are driven 0.
- Latency: with start accepted at edge T0, RUN occupies cycles T0..T(WIDTH). done is high in the cycle after edge T(WIDTH), i.e. WIDTH+1 cycles after acceptance. Throughput is one addition per WIDTH+2 cycles.
- start while in RUN or DONE: ignored, not queued. A start held high through DONE is accepted on the first IDLE edge.
- a_in, b_in and cin_in changing after acceptance: no effect on the running addition.
- sum_out and cout_out:
  - Stable from done until the next accepted start.
  - Not meaningful while busy; partial sum bits are visible.
- Arithmetic: {cout_out, sum_out} = a + b + cin, modulo 2^(WIDTH+1). Overflow out of WIDTH bits is reported only via cout_out.
- idx never exceeds WIDTH-1; no wrap-around within an operation.

Test Plan (WIDTH=8, bench instantiates `full_adder_ds` wired to the fa_* ports):
- a=0x00, b=0x00, cin=0, pulse start → done pulses 9 cycles later; sum_out=0x00, cout_out=0; busy high for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum_out=0x00, cout_out=1 (full carry ripple through all bits).
- a=0xA5, b=0x5A, cin=1 → sum_out=0x00, cout_out=1. Second run a=0x3C, b=0x42, cin=0 → sum_out=0x7E, cout_out=0; previous result held until the second start is accepted.
- Start accepted with a=0x10, b=0x20; pulse start again at RUN cycle 3 with a=0xFF → ignored; result 0x30, cout_out=0; exactly one done pulse.
- Drop rst_n low at RUN cycle 4 → busy=0, sum_out=0, no done. Release rst_n, then start with a=0x01, b=0x01 → sum_out=0x02.
- Exhaustive 4-bit check (WIDTH=4 build): all 512 a/b/cin combinations; {cout_out, sum_out} matches a+b+cin, and done occurs 5 cycles after each start.
